// File: rtl/tx_inband_pkg.sv
// tx_inband_pkg: shared inband TX constants (packet size, header channel field) and router FSM states
package tx_inband_pkg;
  localparam int PKT_WORDS = 128;
  localparam int WCNT_W = $clog2(PKT_WORDS);
  localparam int HDR_CHAN_MSB = 20;
  localparam int HDR_CHAN_LSB = 16;
  localparam logic [4:0] CMD_CHAN_ID = 5'h1F;
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} tx_state_e;
endpackage

// File: rtl/tx_chan_router_if.sv
// tx_chan_router_if: packer-to-channel_ram bus; master = packer/ram side, slave = router
interface tx_chan_router_if #(parameter int NUM_CHAN = 2);
  logic [31:0] usbdata_final;
  logic WR_final;
  logic [NUM_CHAN:0] chan_have_space;
  logic [NUM_CHAN-1:0] chan_txempty;
  logic [31:0] ram_data;
  logic [NUM_CHAN:0] WR_channel;
  logic [NUM_CHAN:0] WR_done_channel;
  logic have_space;
  logic tx_empty;
  logic [15:0] drop_count;
  logic busy;
  modport master (
    output usbdata_final, WR_final, chan_have_space, chan_txempty,
    input ram_data, WR_channel, WR_done_channel, have_space, tx_empty, drop_count, busy
  );
  modport slave (
    input usbdata_final, WR_final, chan_have_space, chan_txempty,
    output ram_data, WR_channel, WR_done_channel, have_space, tx_empty, drop_count, busy
  );
endinterface

// File: rtl/tx_hdr_decode.sv
// tx_hdr_decode: header channel field + per-ram space flags -> dest index, valid, accept (combinational)
module tx_hdr_decode
  import tx_inband_pkg::*;
#(
  parameter int NUM_CHAN = 2
) (
  input  logic [4:0]                       chan,
  input  logic [NUM_CHAN:0]                chan_have_space,
  output logic [$clog2(NUM_CHAN+1)-1:0]    dest,
  output logic                             valid,
  output logic                             accept
);
  localparam int IW = $clog2(NUM_CHAN + 1);
  always_comb begin
    valid = chan == CMD_CHAN_ID || 32'(chan) < NUM_CHAN;
    dest = chan == CMD_CHAN_ID ? IW'(NUM_CHAN) : chan[IW-1:0];
    accept = valid && chan_have_space[dest];
  end
endmodule

// File: rtl/tx_chan_router.sv
// tx_chan_router: steers 128-word inband packets to per-channel/command channel_rams, drops invalid/full
// ports: txclk, reset (sync active-low), bus (tx_chan_router_if.slave: packer word in, ram writes/flags out)
// build option TX_ROUTER_STATS_EN: implements drop_count and busy; otherwise both tie to 0
module tx_chan_router
  import tx_inband_pkg::*;
#(
  parameter int NUM_CHAN = 2
) (
  input logic          txclk,
  input logic          reset,
  tx_chan_router_if.slave bus
);
  localparam int NW = NUM_CHAN + 1;
  localparam int IW = $clog2(NW);
  tx_state_e state, state_n;
  logic [WCNT_W-1:0] wcnt;
  logic [IW-1:0] dest_q, dec_dest, wr_idx;
  logic dec_valid, dec_accept, hdr_ok, last_word, fwd, last_q;
  tx_hdr_decode #(.NUM_CHAN(NUM_CHAN)) u_dec (
    .chan(bus.usbdata_final[HDR_CHAN_MSB:HDR_CHAN_LSB]),
    .chan_have_space(bus.chan_have_space),
    .dest(dec_dest),
    .valid(dec_valid),
    .accept(dec_accept)
  );
  always_comb begin
    hdr_ok = dec_valid && dec_accept;
    last_word = wcnt == WCNT_W'(PKT_WORDS - 1);
    fwd = bus.WR_final && (state == ROUTE || (state == IDLE && hdr_ok));
    wr_idx = state == IDLE ? dec_dest : dest_q;
    state_n = !bus.WR_final ? state :
              state == IDLE ? (hdr_ok ? ROUTE : DROP) :
              last_word ? IDLE : state;
  end
  always_ff @(posedge txclk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // last_q marks the cycle carrying the final write, so WR_done repeats that one-hot a cycle later
  // and is unaffected by a back-to-back header re-latching dest_q
  always_ff @(posedge txclk)
    if (!reset) begin
      wcnt <= '0;
      dest_q <= '0;
      last_q <= 1'b0;
      bus.ram_data <= '0;
      bus.WR_channel <= '0;
      bus.WR_done_channel <= '0;
    end else begin
      if (bus.WR_final) wcnt <= state == IDLE ? WCNT_W'(1) : wcnt + 1'b1;
      if (state == IDLE) dest_q <= dec_dest;
      if (fwd) bus.ram_data <= bus.usbdata_final;
      bus.WR_channel <= fwd ? NW'(1) << wr_idx : '0;
      last_q <= fwd && state == ROUTE && last_word;
      bus.WR_done_channel <= last_q ? bus.WR_channel : '0;
    end
`ifdef TX_ROUTER_STATS_EN
  logic [15:0] drop_q;
  always_ff @(posedge txclk)
    if (!reset) drop_q <= '0;
    else if (bus.WR_final && state == IDLE && !hdr_ok && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
  assign bus.drop_count = drop_q;
  assign bus.busy = state != IDLE;
`else
  assign bus.drop_count = '0;
  assign bus.busy = 1'b0;
`endif
  assign bus.have_space = &bus.chan_have_space;
  assign bus.tx_empty = &bus.chan_txempty;
endmodule

// File: tb/tb_tx_chan_router.sv
// tb_tx_chan_router: randomized scenario bench with a packet-level reference model
module tb_tx_chan_router;
`ifdef TX_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int NC = 2;
  localparam int PW = 128;
  logic txclk = 1'b0;
  logic reset = 1'b0;
  always #5 txclk = ~txclk;
  tx_chan_router_if #(.NUM_CHAN(NC)) bus ();
  tx_chan_router_if #(.NUM_CHAN(4)) bus4 ();
  tx_chan_router #(.NUM_CHAN(NC)) dut (.txclk(txclk), .reset(reset), .bus(bus));
  tx_chan_router #(.NUM_CHAN(4)) dut4 (.txclk(txclk), .reset(reset), .bus(bus4));
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  // packet-level model: position inside packet, destination chosen at the header (-1 = dropped)
  int m_pos = 0, m_cur = -1, m_drop = 0;
  logic [NC:0] exp_wr = '0, exp_done = '0, done_pipe = '0;
  logic [31:0] exp_data = '0;
  logic exp_busy = 1'b0;
  always @(posedge txclk) begin
    int c, idx;
    cyc++;
    if (!reset) begin
      m_pos = 0; m_cur = -1; m_drop = 0;
      exp_wr = '0; exp_done = '0; done_pipe = '0; exp_busy = 1'b0;
    end else begin
      exp_done = done_pipe;
      done_pipe = '0;
      exp_wr = '0;
      if (bus.WR_final) begin
        if (m_pos == 0) begin
          c = int'(bus.usbdata_final[20:16]);
          idx = c == 31 ? NC : (c < NC ? c : -1);
          if (idx >= 0 && bus.chan_have_space[idx]) m_cur = idx;
          else begin
            m_cur = -1;
            if (m_drop < 65535) m_drop++;
          end
        end
        if (m_cur >= 0) begin
          exp_wr = (NC+1)'(1 << m_cur);
          exp_data = bus.usbdata_final;
        end
        m_pos++;
        if (m_pos == PW) begin
          m_pos = 0;
          if (m_cur >= 0) done_pipe = (NC+1)'(1 << m_cur);
        end
      end
      exp_busy = m_pos != 0;
    end
  end
  // monitor: per-cycle agreement with the model plus per-channel event tallies
  bit mon_en = 1'b0;
  int cyc_bad = 0;
  string bad_msg = "";
  int wr_cnt[NC+1], done_cnt[NC+1], wr_cyc[NC+1], done_cyc[NC+1];
  always @(negedge txclk) if (mon_en) begin
    if (bus.WR_channel !== exp_wr || (exp_wr != 0 && bus.ram_data !== exp_data) ||
        bus.WR_done_channel !== exp_done || bus.drop_count !== (STATS ? 16'(m_drop) : 16'd0) ||
        bus.busy !== (STATS ? exp_busy : 1'b0)) begin
      if (cyc_bad == 0)
        bad_msg = $sformatf("cyc %0d wr=%b/%b data=%h/%h done=%b/%b drop=%0d busy=%b", cyc,
                            bus.WR_channel, exp_wr, bus.ram_data, exp_data, bus.WR_done_channel,
                            exp_done, bus.drop_count, bus.busy);
      cyc_bad++;
    end
    for (int i = 0; i <= NC; i++) begin
      if (bus.WR_channel[i] === 1'b1) begin wr_cnt[i]++; wr_cyc[i] = cyc; end
      if (bus.WR_done_channel[i] === 1'b1) begin done_cnt[i]++; done_cyc[i] = cyc; end
    end
  end
  task automatic clear_counts();
    @(posedge txclk);
    #1;
    cyc_bad = 0;
    for (int i = 0; i <= NC; i++) begin wr_cnt[i] = 0; done_cnt[i] = 0; wr_cyc[i] = 0; done_cyc[i] = 0; end
  endtask
  task automatic drive(input logic wf, input logic [31:0] d);
    @(negedge txclk);
    bus.WR_final = wf;
    bus.usbdata_final = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask
  task automatic pulse_reset();
    @(negedge txclk);
    bus.WR_final = 1'b0;
    reset = 1'b0;
    @(negedge txclk);
    reset = 1'b1;
  endtask
  task automatic send_pkt(input int chan, input int gap, input int stop_at, input int kill_at);
    logic [31:0] d;
    for (int w = 0; w < stop_at; w++) begin
      d = $urandom;
      if (w == 0) d[20:16] = 5'(chan);
      drive(1'b1, d);
      if (w == kill_at) bus.chan_have_space = '0;
      for (int g = 0; g < gap; g++) drive(1'b0, $urandom);
    end
  endtask
  task automatic test_reset();
    n_cmp++; if (bus.ram_data !== 32'd0) begin n_bad++; $display("FAIL reset_ram_data got %h want 0", bus.ram_data); end
    n_cmp++; if (bus.WR_channel !== '0) begin n_bad++; $display("FAIL reset_wr_channel got %b want 0", bus.WR_channel); end
    n_cmp++; if (bus.WR_done_channel !== '0) begin n_bad++; $display("FAIL reset_wr_done got %b want 0", bus.WR_done_channel); end
    n_cmp++; if (bus.drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop_count got %0d want 0", bus.drop_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask
  task automatic test_route();
    clear_counts();
    bus.chan_have_space = '1;
    send_pkt(1, 0, PW, -1);
    idle(4);
    n_cmp++; if (wr_cnt[1] !== PW) begin n_bad++; $display("FAIL route_wr_count got %0d want %0d", wr_cnt[1], PW); end
    n_cmp++; if (wr_cnt[0] + wr_cnt[2] !== 0) begin n_bad++; $display("FAIL route_stray_writes got %0d want 0", wr_cnt[0] + wr_cnt[2]); end
    n_cmp++; if (done_cnt[1] !== 1) begin n_bad++; $display("FAIL route_done_count got %0d want 1", done_cnt[1]); end
    n_cmp++; if (done_cyc[1] - wr_cyc[1] !== 1) begin n_bad++; $display("FAIL route_done_latency got %0d want 1", done_cyc[1] - wr_cyc[1]); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL route_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_cmd_and_invalid();
    int bad_chan = $urandom_range(NC, 30);
    pulse_reset();
    clear_counts();
    bus.chan_have_space = '1;
    send_pkt(31, 0, PW, -1);
    send_pkt(bad_chan, 0, PW, -1);
    send_pkt(0, 0, PW, -1);
    idle(4);
    n_cmp++; if (wr_cnt[2] !== PW || done_cnt[2] !== 1) begin n_bad++; $display("FAIL cmd_route got %0d/%0d want %0d/1", wr_cnt[2], done_cnt[2], PW); end
    n_cmp++; if (wr_cnt[0] !== PW || done_cnt[0] !== 1) begin n_bad++; $display("FAIL after_drop_route got %0d/%0d want %0d/1", wr_cnt[0], done_cnt[0], PW); end
    n_cmp++; if (wr_cnt[1] !== 0) begin n_bad++; $display("FAIL invalid_chan_writes got %0d want 0", wr_cnt[1]); end
    n_cmp++; if (bus.drop_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL invalid_drop_count got %0d want %0d", bus.drop_count, STATS ? 1 : 0); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL cmd_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_no_space();
    pulse_reset();
    clear_counts();
    bus.chan_have_space = 3'b110;
    send_pkt(0, 0, PW, -1);
    bus.chan_have_space = '1;
    send_pkt(0, 0, PW, 1);
    idle(4);
    bus.chan_have_space = '1;
    n_cmp++; if (wr_cnt[0] !== PW || done_cnt[0] !== 1) begin n_bad++; $display("FAIL space_loss_mid got %0d/%0d want %0d/1", wr_cnt[0], done_cnt[0], PW); end
    n_cmp++; if (bus.drop_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL no_space_drop got %0d want %0d", bus.drop_count, STATS ? 1 : 0); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL no_space_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_gapped();
    clear_counts();
    send_pkt(1, 3, PW, -1);
    idle(4);
    n_cmp++; if (wr_cnt[1] !== PW || done_cnt[1] !== 1) begin n_bad++; $display("FAIL gapped_count got %0d/%0d want %0d/1", wr_cnt[1], done_cnt[1], PW); end
    n_cmp++; if (done_cyc[1] - wr_cyc[1] !== 1) begin n_bad++; $display("FAIL gapped_done_latency got %0d want 1", done_cyc[1] - wr_cyc[1]); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL gapped_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_reset_mid();
    int ch = $urandom_range(0, NC - 1);
    clear_counts();
    send_pkt(0, 0, 60, -1);
    pulse_reset();
    n_cmp++; if (bus.WR_channel !== '0 || bus.WR_done_channel !== '0 || bus.ram_data !== 32'd0 || bus.busy !== 1'b0 || bus.drop_count !== 16'd0)
      begin n_bad++; $display("FAIL midreset_outputs got wr=%b done=%b data=%h busy=%b drop=%0d want all 0", bus.WR_channel, bus.WR_done_channel, bus.ram_data, bus.busy, bus.drop_count); end
    idle(4);
    n_cmp++; if (wr_cnt[0] !== 60 || done_cnt[0] !== 0) begin n_bad++; $display("FAIL midreset_partial got %0d/%0d want 60/0", wr_cnt[0], done_cnt[0]); end
    clear_counts();
    send_pkt(ch, 0, PW, -1);
    idle(4);
    n_cmp++; if (wr_cnt[ch] !== PW || done_cnt[ch] !== 1) begin n_bad++; $display("FAIL midreset_next got %0d/%0d want %0d/1", wr_cnt[ch], done_cnt[ch], PW); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL midreset_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_back_to_back();
    int ew[NC+1], ed[NC+1], edrop, c, idx;
    logic [NC:0] sp;
    pulse_reset();
    clear_counts();
    edrop = 0;
    for (int i = 0; i <= NC; i++) begin ew[i] = 0; ed[i] = 0; end
    for (int p = 0; p < 8; p++) begin
      case ($urandom_range(0, 3))
        0: c = 0;
        1: c = 1;
        2: c = 31;
        default: c = $urandom_range(NC, 30);
      endcase
      sp = ($urandom_range(0, 3) == 0) ? (NC+1)'($urandom) : '1;
      idx = c == 31 ? NC : (c < NC ? c : -1);
      if (idx >= 0 && sp[idx]) begin ew[idx] += PW; ed[idx]++; end
      else edrop++;
      bus.chan_have_space = sp;
      send_pkt(c, 0, PW, -1);
    end
    idle(4);
    bus.chan_have_space = '1;
    for (int i = 0; i <= NC; i++) begin
      n_cmp++; if (wr_cnt[i] !== ew[i] || done_cnt[i] !== ed[i]) begin n_bad++; $display("FAIL b2b_chan%0d got %0d/%0d want %0d/%0d", i, wr_cnt[i], done_cnt[i], ew[i], ed[i]); end
    end
    n_cmp++; if (bus.drop_count !== (STATS ? 16'(edrop) : 16'd0)) begin n_bad++; $display("FAIL b2b_drop got %0d want %0d", bus.drop_count, STATS ? edrop : 0); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL b2b_model got %0d bad cycles want 0: %s", cyc_bad, bad_msg); end
  endtask
  task automatic test_flags();
    logic [NC:0] sp;
    logic [NC-1:0] te;
    @(negedge txclk);
    bus4.chan_txempty = 4'b1110;
    #1;
    n_cmp++; if (bus4.tx_empty !== 1'b0) begin n_bad++; $display("FAIL tx_empty4_1110 got %b want 0", bus4.tx_empty); end
    bus4.chan_txempty = 4'b1111;
    #1;
    n_cmp++; if (bus4.tx_empty !== 1'b1) begin n_bad++; $display("FAIL tx_empty4_1111 got %b want 1", bus4.tx_empty); end
    for (int i = 0; i < 8; i++) begin
      sp = (NC+1)'($urandom);
      te = NC'($urandom);
      bus.chan_have_space = sp;
      bus.chan_txempty = te;
      #1;
      n_cmp++; if (bus.have_space !== (sp == '1)) begin n_bad++; $display("FAIL have_space %b got %b want %b", sp, bus.have_space, sp == '1); end
      n_cmp++; if (bus.tx_empty !== (te == '1)) begin n_bad++; $display("FAIL tx_empty %b got %b want %b", te, bus.tx_empty, te == '1); end
    end
    bus.chan_have_space = '1;
    bus.chan_txempty = '1;
  endtask
  initial begin
    bus.WR_final = 1'b0;
    bus.usbdata_final = '0;
    bus.chan_have_space = '1;
    bus.chan_txempty = '1;
    bus4.WR_final = 1'b0;
    bus4.usbdata_final = '0;
    bus4.chan_have_space = '1;
    bus4.chan_txempty = '1;
    repeat (3) @(negedge txclk);
    test_reset();
    mon_en = 1'b1;
    reset = 1'b1;
    test_route();
    test_cmd_and_invalid();
    test_no_space();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    test_flags();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_chan_router.md
# tx_chan_router

Parametrised USB-to-channel packet router for the inband TX path. It replaces the fixed two-channel demux/space/empty glue with one block sized by `NUM_CHAN`. It takes 32-bit words from the TX packer, decodes the inband header channel field and steers each 128-word packet into the matching per-channel `channel_ram` or the command `channel_ram`. Packets for a missing or full channel are dropped and counted, and the block produces the aggregate `have_space`/`tx_empty` flags for any channel count.

## Interface
- `NUM_CHAN`, 2, data channels, 1..31; the command channel occupies index `NUM_CHAN`
- `PKT_WORDS`, 128, 32-bit words per inband packet, including the header
- `txclk`  in  1  sole clock
- `reset`  in  1  synchronous, active-low; `reset==0` at a `txclk` edge resets the block
- `usbdata_final`  in  32  packed USB word from the packer
- `WR_final`  in  1  qualifies `usbdata_final`, one word per cycle when high
- `chan_have_space`  in  NUM_CHAN+1  per-`channel_ram` space flag, sampled at header
- `chan_txempty`  in  NUM_CHAN  per-data-channel empty flag
- `ram_data`  out  32  registered word to all `channel_ram`s
- `WR_channel`  out  NUM_CHAN+1  one-hot write strobe
- `WR_done_channel`  out  NUM_CHAN+1  one-hot end-of-packet pulse
- `have_space`  out  1  AND of all `chan_have_space` bits, including command
- `tx_empty`  out  1  AND of all `chan_txempty` bits
- `drop_count`  out  16  packets discarded since reset, saturating
- `busy`  out  1  high while not in IDLE

## Operation
- Header word: `chan = usbdata_final[20:16]`. `5'h1F` maps to index `NUM_CHAN`. Values 0..NUM_CHAN-1 map to the same index. Any other value is invalid.
- FSM states are IDLE, ROUTE and DROP. The word counter `wcnt` (log2 PKT_WORDS bits) advances only on `WR_final`.
- IDLE + `WR_final`, valid `chan`, and `chan_have_space[dest]`=1:
  - latch `dest`
  - forward the header word
  - set `wcnt`=1
  - go to ROUTE
- IDLE + `WR_final`, invalid `chan` or no space:
  - `drop_count`++ (saturates at 16'hFFFF)
  - set `wcnt`=1
  - go to DROP; nothing is forwarded
- ROUTE: each `WR_final` word is forwarded to `dest`. On word `PKT_WORDS-1`, return to IDLE and schedule `WR_done_channel[dest]`.
- DROP: words are consumed silently. On word `PKT_WORDS-1`, return to IDLE.
- `chan_have_space` is sampled only at the header. Later deassertion mid-packet does not abort the packet; `channel_ram` sizing guarantees one full packet.
- No-`WR_final` cycles inside a packet are permitted and hold state and `wcnt`.
- Reset mid-packet: the partial packet is abandoned, with no `WR_done`. The next `WR_final` word after release is treated as a header.
- `have_space` and `tx_empty` are combinational reductions.

## Timing
- Reset values: `ram_data`=0, `WR_channel`=0, `WR_done_channel`=0, `drop_count`=0, `busy`=0, state IDLE, `wcnt`=0.
- Latency: `ram_data`/`WR_channel[dest]` are valid exactly 1 cycle after the accepting `WR_final` cycle. `WR_channel` is a single-cycle pulse per word.
- `WR_done_channel[dest]` pulses for 1 cycle, in the cycle after the final `WR_channel[dest]` pulse (2 cycles after the last `WR_final`).
- Back-to-back packets: a header arriving in the cycle after the last word is accepted normally. A `WR_done` of packet N may coincide with a `WR_channel` of packet N+1 (different or same index); both are legal.
- At most one bit of `WR_channel` is set per cycle. At most one bit of `WR_done_channel` is set per cycle.

## Configuration
- `TX_ROUTER_STATS_EN` defined:
  - `drop_count` is implemented as above.
  - `busy` is driven.
- `TX_ROUTER_STATS_EN` undefined:
  - `drop_count` is tied to 0 and `busy` to 0; no counter flops.
  - Routing and dropping behaviour is unchanged.

## Structure
- Shared package `tx_inband_pkg`:
  - `PKT_WORDS`=128
  - `HDR_CHAN_MSB`=20, `HDR_CHAN_LSB`=16
  - `CMD_CHAN_ID`=5'h1F
  - FSM state typedef (IDLE/ROUTE/DROP)
- One sub-module, `tx_hdr_decode`: maps the header word plus `chan_have_space` to `dest` index, `valid` and `accept`. It is combinational and parametrised by `NUM_CHAN`.

## Test plan
- `NUM_CHAN`=2, chan 1 with space, 128 contiguous words → 128 `WR_channel[1]` pulses carrying identical data at +1 cycle, then a single `WR_done_channel[1]` pulse at +2 after the last word.
- Header chan `5'h1F` → routed to index 2 (command). Header chan 5 with `NUM_CHAN`=2 → no writes, `drop_count`=1, and the next header routes normally.
- `chan_have_space[0]`=0 at header → packet dropped, `drop_count` increments. If space drops after header accept, the full packet is still delivered.
- `WR_final` gapped (1 on / 3 off) → 128 writes total, `wcnt` held during gaps, `WR_done` timing relative to the last write unchanged.
- Reset (`reset`=0 for 1 cycle) at word 60 → all outputs 0, no `WR_done`. The following packet is decoded from its own header and delivered completely.
- `NUM_CHAN`=4, `chan_txempty`=4'b1110 → `tx_empty`=0. Then 4'b1111 → `tx_empty`=1.
